hazard_scoreboard: RTL

//   ID-stage load-use hazard controller for the pipelined RISC-V core; the producer of the

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/hazard_sb_entry.sv | 31 +++
 rtl/hazard_scoreboard.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path constants for the pipelined RISC-V core: register file
// geometry and the base opcodes seen by the ID-stage decoders.
package cpu_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: counts down the bubbles still owed to a pending load
// on a single architectural register.
module hazard_sb_entry #(
    parameter int CNT_W    = 2,
    parameter int LOAD_VAL = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic hold_i,
    input  logic load_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt;

    // A fresh load wins over the decrement, restarting any count already pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (!hold_i) begin
            if (load_i) begin
                cnt <= CNT_W'(LOAD_VAL);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy_o = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage load-use hazard controller: per-register countdown scoreboard,
// pipeline write enables, taken-branch flush and a saturating bubble counter.
module hazard_scoreboard
    import cpu_ctrl_pkg::*;
#(
    parameter int LOAD_USE_GAP = 1,
    parameter int CNT_W        = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  MemRead_i,
    input  logic                  RegWrite_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_stall_i,
    output logic                  NoOp_o,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  Flush_o,
    output logic [31:0]           stall_cnt_o
);

    logic [NUM_REGS-1:0] busy;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                hazard;
    logic                issue;
    logic                load_en;

    // x0 is never tracked, so its slot is permanently idle.
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W   (CNT_W),
            .LOAD_VAL(LOAD_USE_GAP)
        ) u_entry (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .hold_i (mem_stall_i),
            .load_i (load_en && (rd_addr_i == REG_ADDR_W'(i))),
            .busy_o (busy[i])
        );
    end

    assign rs1_hit = rs1_used_i && (rs1_addr_i != '0) && busy[rs1_addr_i];
    assign rs2_hit = rs2_used_i && (rs2_addr_i != '0) && busy[rs2_addr_i];
    assign hazard  = id_valid_i && (rs1_hit || rs2_hit);
    assign issue   = id_valid_i && !hazard && !mem_stall_i;
    assign load_en = issue && MemRead_i && RegWrite_i && (rd_addr_i != '0);

    // Reset forces a bubble; a memory freeze outranks a hazard, which outranks a branch flush.
    always_comb begin
        NoOp_o      = 1'b0;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        Flush_o     = branch_taken_i;
        if (!rst_n_i) begin
            NoOp_o      = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            Flush_o     = 1'b0;
        end else if (mem_stall_i) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            Flush_o     = 1'b0;
        end else if (hazard) begin
            NoOp_o      = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            Flush_o     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (!mem_stall_i && hazard && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule
